// File: rtl/fecha_edit_ctrl_if.sv
// Signal bundle between the date/time edit sequencer and its surroundings:
// debounced buttons, counter-bank values and strobes, and the RTC write
// request/acknowledge pair. The sequencer takes the master view.
interface fecha_edit_ctrl_if;
    // One-cycle debounced button pulses
    logic       btn_edit;
    logic       btn_next;
    logic       btn_up;
    logic       btn_down;

    // Current values of the day/month/year counters (binary)
    logic [7:0] day_val;
    logic [7:0] month_val;
    logic [7:0] year_val;

    // RTC write handshake
    logic       wr_req;
    logic       wr_ack;

    // Edit status and counter strobes
    logic       editing;
    logic [2:0] field_sel;
    logic [5:0] inc_str;
    logic [5:0] dec_str;

    modport master (
        input  btn_edit,
        input  btn_next,
        input  btn_up,
        input  btn_down,
        input  day_val,
        input  month_val,
        input  year_val,
        input  wr_ack,
        output wr_req,
        output editing,
        output field_sel,
        output inc_str,
        output dec_str
    );

    modport slave (
        output btn_edit,
        output btn_next,
        output btn_up,
        output btn_down,
        output day_val,
        output month_val,
        output year_val,
        output wr_ack,
        input  wr_req,
        input  editing,
        input  field_sel,
        input  inc_str,
        input  dec_str
    );
endinterface

// File: rtl/fecha_edit_ctrl.sv
// Edit-mode sequencer for the date/time counter bank. Converts button pulses
// into one-cycle inc/dec strobes for the selected field, walks the day back
// down after a month/year change leaves it out of range, and hands the new
// time to the RTC through a req/ack handshake when edit mode is left.
module fecha_edit_ctrl #(
    parameter bit LEAP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    fecha_edit_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EDIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    localparam logic [2:0] FLD_DAY   = 3'd3;
    localparam logic [2:0] FLD_MONTH = 3'd4;
    localparam logic [2:0] FLD_YEAR  = 3'd5;

    state_t     state_reg,     state_next;
    logic [2:0] field_sel_reg, field_sel_next;
    logic       exiting_reg,   exiting_next;
    logic [5:0] inc_str_reg,   inc_str_next;
    logic [5:0] dec_str_reg,   dec_str_next;
    logic       wr_req_reg,    wr_req_next;
    logic       editing_reg,   editing_next;

    logic [7:0] max_day;
    logic [5:0] field_hot;
    logic       field_is_day;
    logic       field_needs_clamp;

    // Last legal day of the current month; illegal month codes fall back to 31
    // so the clamp never fires on garbage input.
    always_comb begin
        max_day = 8'd31;
        case (bus.month_val)
            8'd4, 8'd6, 8'd9, 8'd11: max_day = 8'd30;
            8'd2: begin
                if (LEAP_EN && (bus.year_val[1:0] == 2'b00)) begin
                    max_day = 8'd29;
                end else begin
                    max_day = 8'd28;
                end
            end
            default: max_day = 8'd31;
        endcase
    end

    // One-hot decode of the selected field; codes 6 and 7 never occur and
    // decode to no strobe at all.
    for (genvar gi = 0; gi < 6; gi++) begin : g_field_hot
        assign field_hot[gi] = (field_sel_reg == 3'(gi));
    end

    assign field_is_day      = (field_sel_reg == FLD_DAY);
    assign field_needs_clamp = (field_sel_reg == FLD_MONTH) || (field_sel_reg == FLD_YEAR);

    // Next-state and next-output logic; every output register is a function
    // of the transition being taken so all outputs come straight off flops.
    always_comb begin
        state_next     = state_reg;
        field_sel_next = field_sel_reg;
        exiting_next   = exiting_reg;
        inc_str_next   = 6'd0;
        dec_str_next   = 6'd0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.btn_edit) begin
                    state_next     = ST_EDIT;
                    field_sel_next = 3'd0;
                end
            end

            ST_EDIT: begin
                // Only the highest-priority button in a cycle is acted on.
                if (bus.btn_edit) begin
                    state_next   = ST_SETTLE;
                    exiting_next = 1'b1;
                end else if (bus.btn_next) begin
                    if (field_sel_reg >= FLD_YEAR) begin
                        field_sel_next = 3'd0;
                    end else begin
                        field_sel_next = field_sel_reg + 3'd1;
                    end
                end else if (bus.btn_up && bus.btn_down) begin
                    // Contradictory request: ignore both.
                end else if (bus.btn_up) begin
                    if (field_is_day) begin
                        // Day saturates at the end of the month instead of wrapping.
                        if (bus.day_val < max_day) begin
                            inc_str_next = field_hot;
                        end
                    end else begin
                        inc_str_next = field_hot;
                        if (field_needs_clamp) begin
                            state_next   = ST_SETTLE;
                            exiting_next = 1'b0;
                        end
                    end
                end else if (bus.btn_down) begin
                    if (field_is_day) begin
                        // Day never goes below 1.
                        if (bus.day_val > 8'd1) begin
                            dec_str_next = field_hot;
                        end
                    end else begin
                        dec_str_next = field_hot;
                        if (field_needs_clamp) begin
                            state_next   = ST_SETTLE;
                            exiting_next = 1'b0;
                        end
                    end
                end
            end

            ST_SETTLE: begin
                // Give the counter one edge to absorb the last strobe.
                state_next = ST_CHECK;
            end

            ST_CHECK: begin
                if (bus.day_val > max_day) begin
                    dec_str_next[FLD_DAY] = 1'b1;
                    state_next            = ST_SETTLE;
                end else if (exiting_reg) begin
                    state_next = ST_COMMIT;
                end else begin
                    state_next = ST_EDIT;
                end
            end

            ST_COMMIT: begin
                if (bus.wr_ack) begin
                    state_next   = ST_IDLE;
                    exiting_next = 1'b0;
                end
            end

            default: begin
                state_next   = ST_IDLE;
                exiting_next = 1'b0;
            end
        endcase

        wr_req_next  = (state_next == ST_COMMIT);
        editing_next = (state_next == ST_EDIT) || (state_next == ST_SETTLE) ||
                       (state_next == ST_CHECK);
    end

    // State and output registers; reset clears everything at once, abandoning
    // any clamp or pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            field_sel_reg <= 3'd0;
            exiting_reg   <= 1'b0;
            inc_str_reg   <= 6'd0;
            dec_str_reg   <= 6'd0;
            wr_req_reg    <= 1'b0;
            editing_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            field_sel_reg <= field_sel_next;
            exiting_reg   <= exiting_next;
            inc_str_reg   <= inc_str_next;
            dec_str_reg   <= dec_str_next;
            wr_req_reg    <= wr_req_next;
            editing_reg   <= editing_next;
        end
    end

    assign bus.editing   = editing_reg;
    assign bus.field_sel = field_sel_reg;
    assign bus.inc_str   = inc_str_reg;
    assign bus.dec_str   = dec_str_reg;
    assign bus.wr_req    = wr_req_reg;

endmodule

// File: tb/tb_fecha_edit_ctrl.sv
// Directed bench for fecha_edit_ctrl: one instance with leap years enabled
// driving a small day/month/year counter model, and one with leap years
// disabled whose day counter only counts down.
module tb_fecha_edit_ctrl;

    logic clk;
    logic reset;

    fecha_edit_ctrl_if bus();
    fecha_edit_ctrl_if bus_nl();

    fecha_edit_ctrl #(.LEAP_EN(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fecha_edit_ctrl #(.LEAP_EN(1'b0)) u_dut_nl (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Counter model for the leap instance, loadable from the stimulus.
    logic       ld;
    logic [7:0] ld_day, ld_month, ld_year;
    logic [7:0] m_day, m_month, m_year;

    always_ff @(posedge clk) begin
        if (ld) begin
            m_day   <= ld_day;
            m_month <= ld_month;
            m_year  <= ld_year;
        end else begin
            if (bus.inc_str[3])      m_day <= m_day + 8'd1;
            else if (bus.dec_str[3]) m_day <= m_day - 8'd1;
            if (bus.inc_str[4])      m_month <= (m_month == 8'd12) ? 8'd1 : m_month + 8'd1;
            else if (bus.dec_str[4]) m_month <= (m_month == 8'd1) ? 8'd12 : m_month - 8'd1;
            if (bus.inc_str[5])      m_year <= (m_year == 8'd99) ? 8'd0 : m_year + 8'd1;
            else if (bus.dec_str[5]) m_year <= (m_year == 8'd0) ? 8'd99 : m_year - 8'd1;
        end
    end

    assign bus.day_val   = m_day;
    assign bus.month_val = m_month;
    assign bus.year_val  = m_year;

    // Non-leap instance: February of year 24, day starts at 29 and only decrements.
    logic       nl_ld;
    logic [7:0] nl_day;

    always_ff @(posedge clk) begin
        if (nl_ld)                  nl_day <= 8'd29;
        else if (bus_nl.dec_str[3]) nl_day <= nl_day - 8'd1;
    end

    assign bus_nl.day_val   = nl_day;
    assign bus_nl.month_val = 8'd2;
    assign bus_nl.year_val  = 8'd24;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    // Buttons: 0 edit, 1 next, 2 up, 3 down. Called just after a falling edge;
    // returns one cycle later with the pulse sampled by exactly one rising edge.
    task automatic press(input int b);
        case (b)
            0: bus.btn_edit = 1'b1;
            1: bus.btn_next = 1'b1;
            2: bus.btn_up   = 1'b1;
            default: bus.btn_down = 1'b1;
        endcase
        @(negedge clk);
        bus.btn_edit = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
    endtask

    task automatic press_nl(input int b);
        case (b)
            0: bus_nl.btn_edit = 1'b1;
            1: bus_nl.btn_next = 1'b1;
            2: bus_nl.btn_up   = 1'b1;
            default: bus_nl.btn_down = 1'b1;
        endcase
        @(negedge clk);
        bus_nl.btn_edit = 1'b0;
        bus_nl.btn_next = 1'b0;
        bus_nl.btn_up   = 1'b0;
        bus_nl.btn_down = 1'b0;
    endtask

    task automatic load(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
        ld_day   = d;
        ld_month = m;
        ld_year  = y;
        ld       = 1'b1;
        @(negedge clk);
        ld       = 1'b0;
    endtask

    // Watchdog: the directed sequence is a few hundred cycles at most.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [5:0] exp_dec;
        int         pulses;

        reset = 1'b0;
        bus.btn_edit = 1'b0; bus.btn_next = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
        bus.wr_ack = 1'b0;
        bus_nl.btn_edit = 1'b0; bus_nl.btn_next = 1'b0; bus_nl.btn_up = 1'b0; bus_nl.btn_down = 1'b0;
        bus_nl.wr_ack = 1'b0;
        ld = 1'b1; ld_day = 8'd15; ld_month = 8'd6; ld_year = 8'd23;
        nl_ld = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ld = 1'b0;
        nl_ld = 1'b0;

        // Reset state
        check("rst_editing", 32'(bus.editing), 32'd0);
        check("rst_field",   32'(bus.field_sel), 32'd0);
        check("rst_inc",     32'(bus.inc_str), 32'd0);
        check("rst_dec",     32'(bus.dec_str), 32'd0);
        check("rst_wr_req",  32'(bus.wr_req), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Idle ignores up
        press(2);
        check("idle_up_inc", 32'(bus.inc_str), 32'd0);
        check("idle_up_editing", 32'(bus.editing), 32'd0);

        // Enter edit and cycle fields
        press(0);
        check("enter_editing", 32'(bus.editing), 32'd1);
        check("enter_field", 32'(bus.field_sel), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            press(1);
            check($sformatf("next_field_%0d", i), 32'(bus.field_sel), 32'(i % 6));
        end

        // Up and down together on seconds: nothing
        bus.btn_up = 1'b1;
        bus.btn_down = 1'b1;
        @(negedge clk);
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        check("both_inc", 32'(bus.inc_str), 32'd0);
        check("both_dec", 32'(bus.dec_str), 32'd0);

        // Up on seconds: one-cycle strobe
        press(2);
        check("sec_up_inc", 32'(bus.inc_str), 32'h01);
        @(negedge clk);
        check("sec_up_inc_drop", 32'(bus.inc_str), 32'd0);

        // Day field limits
        press(1); press(1); press(1);
        check("day_field", 32'(bus.field_sel), 32'd3);
        load(8'd28, 8'd2, 8'd23);
        press(2);
        check("day_sat_up", 32'(bus.inc_str), 32'd0);
        load(8'd1, 8'd2, 8'd23);
        press(3);
        check("day_sat_down", 32'(bus.dec_str), 32'd0);
        load(8'd10, 8'd2, 8'd23);
        press(2);
        check("day_up_inc", 32'(bus.inc_str), 32'h08);

        // Month 1 -> 2 with day 31: three clamp decrements, 2 cycles apart
        load(8'd31, 8'd1, 8'd23);
        press(1);
        check("month_field", 32'(bus.field_sel), 32'd4);
        press(2);
        check("month_up_inc", 32'(bus.inc_str), 32'h10);
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_dec = (k == 2 || k == 4 || k == 6) ? 6'h08 : 6'h00;
            if (bus.dec_str[3]) pulses++;
            check($sformatf("clamp_dec_c%0d", k), 32'(bus.dec_str), 32'(exp_dec));
        end
        check("clamp_pulses", 32'(pulses), 32'd3);
        check("clamp_day", 32'(m_day), 32'd28);
        check("clamp_month", 32'(m_month), 32'd2);
        press(1);
        check("clamp_back_edit", 32'(bus.field_sel), 32'd5);

        // Year 23 -> 24 with Feb 29: leap year, no clamp
        load(8'd29, 8'd2, 8'd23);
        press(2);
        check("year_up_inc", 32'(bus.inc_str), 32'h20);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("leap_dec_c%0d", k), 32'(bus.dec_str), 32'd0);
        end
        check("leap_year", 32'(m_year), 32'd24);
        check("leap_day", 32'(m_day), 32'd29);
        check("leap_editing", 32'(bus.editing), 32'd1);

        // Same stimulus with leap years disabled: one clamp pulse
        press_nl(0);
        for (int i = 0; i < 5; i++) press_nl(1);
        check("nl_field", 32'(bus_nl.field_sel), 32'd5);
        press_nl(2);
        check("nl_year_inc", 32'(bus_nl.inc_str), 32'h20);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_dec = (k == 2) ? 6'h08 : 6'h00;
            check($sformatf("nl_dec_c%0d", k), 32'(bus_nl.dec_str), 32'(exp_dec));
        end
        check("nl_day", 32'(nl_day), 32'd28);

        // Leave edit: wr_req rises after SETTLE and CHECK, holds until ack
        press(0);
        check("exit_settle_req", 32'(bus.wr_req), 32'd0);
        @(negedge clk);
        check("exit_check_req", 32'(bus.wr_req), 32'd0);
        @(negedge clk);
        check("commit_req", 32'(bus.wr_req), 32'd1);
        check("commit_editing", 32'(bus.editing), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("commit_hold_%0d", k), 32'(bus.wr_req), 32'd1);
        end
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
        check("ack_req", 32'(bus.wr_req), 32'd0);
        check("ack_editing", 32'(bus.editing), 32'd0);
        check("ack_field_kept", 32'(bus.field_sel), 32'd5);
        press(2);
        check("after_commit_up", 32'(bus.inc_str), 32'd0);

        // Ack in the first COMMIT cycle: single-cycle request
        press(0);
        check("reenter_field", 32'(bus.field_sel), 32'd0);
        press(0);
        @(negedge clk);
        @(negedge clk);
        check("pulse_req_high", 32'(bus.wr_req), 32'd1);
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
        check("pulse_req_low", 32'(bus.wr_req), 32'd0);

        // Reset while wr_req is high
        press(0);
        press(0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_req", 32'(bus.wr_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_commit_req", 32'(bus.wr_req), 32'd0);
        check("rst_commit_editing", 32'(bus.editing), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        press(2);
        check("rst_commit_up", 32'(bus.inc_str), 32'd0);

        // Reset during a clamp sequence
        press(0);
        for (int i = 0; i < 4; i++) press(1);
        load(8'd31, 8'd1, 8'd23);
        press(2);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_dec", 32'(bus.dec_str), 32'h08);
        #2 reset = 1'b0;
        #1;
        check("rst_clamp_dec", 32'(bus.dec_str), 32'd0);
        check("rst_clamp_editing", 32'(bus.editing), 32'd0);
        check("rst_clamp_field", 32'(bus.field_sel), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        press(2);
        check("rst_clamp_up", 32'(bus.inc_str), 32'd0);
        check("rst_clamp_idle", 32'(bus.editing), 32'd0);
        press(0);
        check("rst_clamp_reenter", 32'(bus.editing), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
